// File: rtl/fd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fd_gen
//  Purpose  : Multi-channel programmable clock divider. Each channel divides
//             clk_in by a ratio N with a programmable high time H. Ratio and
//             high time are shadow-loaded only at period boundaries, so
//             changing them mid-period never produces a runt pulse.
//  Ports    : clk_in   - sole clock, rising edge
//             rst      - synchronous active-high reset
//             en       - [CH] per-channel run enable
//             n_div    - [CH*WIDTH] divide ratio, channel k at [k*WIDTH +: WIDTH]
//             duty     - [CH*WIDTH] high time in clk_in cycles, same packing
//             clk_out  - [CH] registered divided clock
//             tick     - [CH] pulse on the first high cycle of each period
//             err      - [CH] high while the active ratio is below 2
//  Config   : FD_GEN_DUTY_EN defined   -> high time taken from duty
//             FD_GEN_DUTY_EN undefined -> duty ignored, H = ceil(N/2)
//  Revision : 1.0 - initial release
// ============================================================================
module fd_gen #(
    parameter int WIDTH = 32,
    parameter int CH    = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [CH-1:0]         en,
    input  logic [CH*WIDTH-1:0]   n_div,
    input  logic [CH*WIDTH-1:0]   duty,
    output logic [CH-1:0]         clk_out,
    output logic [CH-1:0]         tick,
    output logic [CH-1:0]         err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_zero = '0;

`ifndef FD_GEN_DUTY_EN
    // duty carries no information in this build; it is folded to a constant
    // zero so the port stays referenced without influencing the logic.
    logic w_duty_fold;
    assign w_duty_fold = (^duty) & 1'b0;
`endif

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [WIDTH-1:0] w_n;
        logic [WIDTH-1:0] w_h;
        logic             w_n_ok;
        logic             w_na_ok;
        logic             w_wrap;
        logic [WIDTH-1:0] w_cnt_nxt;

        logic [0:0]       r_state;
        logic [WIDTH-1:0] r_na;
        logic [WIDTH-1:0] r_ha;
        logic [WIDTH-1:0] r_cnt;
        logic             r_clk;
        logic             r_tick;
        logic             r_err;

        assign w_n = n_div[k*WIDTH +: WIDTH];

`ifdef FD_GEN_DUTY_EN
        assign w_h = duty[k*WIDTH +: WIDTH];
`else
        // ceil(N/2) without an adder carry-out: N - floor(N/2)
        assign w_h = (w_n - (w_n >> 1)) | {WIDTH{w_duty_fold}};
`endif

        assign w_n_ok    = (w_n > c_one);
        assign w_na_ok   = (r_na > c_one);
        // Only meaningful when r_na >= 2, so r_na - 1 never underflows here.
        assign w_wrap    = (r_cnt == (r_na - c_one));
        // r_cnt < r_na - 1 on this path, so the increment cannot overflow.
        assign w_cnt_nxt = r_cnt + c_one;

        always_ff @(posedge clk_in) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_na    <= c_zero;
                r_ha    <= c_zero;
                r_cnt   <= c_zero;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
                r_err   <= 1'b0;
            end else if (!en[k]) begin
                // Idle: outputs parked low, shadows track the inputs.
                r_state <= S_IDLE;
                r_na    <= w_n;
                r_ha    <= w_h;
                r_cnt   <= c_zero;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
                r_err   <= 1'b0;
            end else if ((r_state == S_IDLE) || !w_na_ok || w_wrap) begin
                // Start of a new period: on enable, at a wrap, or while the
                // active ratio is invalid (re-sampling every cycle until the
                // ratio becomes usable).
                r_state <= S_RUN;
                r_na    <= w_n;
                r_ha    <= w_h;
                r_cnt   <= c_zero;
                r_tick  <= w_n_ok;
                r_clk   <= w_n_ok && (w_h != c_zero);
                r_err   <= !w_n_ok;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_tick  <= 1'b0;
                r_clk   <= (w_cnt_nxt < r_ha);
                r_err   <= 1'b0;
            end
        end

        assign clk_out[k] = r_clk;
        assign tick[k]    = r_tick;
        assign err[k]     = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_fd_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_gen
//  Purpose  : Self-checking bench for fd_gen. A period-position model tracks
//             each channel and is compared against the outputs every cycle;
//             directed sequences add literal pattern checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fd_gen;

    localparam int W  = 8;
    localparam int CH = 2;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] n_div;
    logic [CH*W-1:0] duty;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    fd_gen #(.WIDTH(W), .CH(CH)) dut (
        .clk_in  (clk),
        .rst     (rst),
        .en      (en),
        .n_div   (n_div),
        .duty    (duty),
        .clk_out (clk_out),
        .tick    (tick),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is described by whether it runs, its active ratio/high
    // time, and its position within the current period.
    bit     m_run [CH];
    longint m_na  [CH];
    longint m_ha  [CH];
    longint m_pos [CH];
    longint mn, mh;

    always @(posedge clk) begin
        for (int k = 0; k < CH; k++) begin
            mn = longint'(n_div[k*W +: W]);
`ifdef FD_GEN_DUTY_EN
            mh = longint'(duty[k*W +: W]);
`else
            mh = (mn + 1) / 2;
`endif
            if (rst) begin
                m_run[k] = 0; m_na[k] = 0; m_ha[k] = 0; m_pos[k] = 0;
            end else if (!en[k]) begin
                m_run[k] = 0; m_na[k] = mn; m_ha[k] = mh; m_pos[k] = 0;
            end else if (!m_run[k] || m_na[k] < 2 || m_pos[k] == m_na[k] - 1) begin
                m_run[k] = 1; m_na[k] = mn; m_ha[k] = mh; m_pos[k] = 0;
            end else begin
                m_pos[k] = m_pos[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < CH; k++) begin
                bit ok;
                ok = m_run[k] && (m_na[k] >= 2);
                chk($sformatf("ch%0d_clk", k), clk_out[k], (ok && m_pos[k] < m_ha[k]) ? 1 : 0);
                chk($sformatf("ch%0d_tick", k), tick[k], (ok && m_pos[k] == 0) ? 1 : 0);
                chk($sformatf("ch%0d_err", k), err[k], (m_run[k] && m_na[k] < 2) ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_d(input int k, input logic e, input int n, input int d);
        en[k] = e;
        n_div[k*W +: W] = W'(n);
        duty[k*W +: W]  = W'(d);
    endtask

    // Duty equal to ceil(N/2) so literal expectations hold in either build.
    task automatic set_ch(input int k, input logic e, input int n);
        set_d(k, e, n, n - n / 2);
    endtask

    logic [8:0] v0, v1, t0, t1;
    int ticks, highs;

    initial begin
        rst = 1'b1; en = '0; n_div = '0; duty = '0;
        repeat (3) @(negedge clk);
        chk("reset_clk", clk_out, 0);
        chk("reset_tick", tick, 0);
        chk("reset_err", err, 0);
        chk_on = 1;

        // Two channels, N=2 and N=3, enabled straight out of reset
        set_ch(0, 1, 2); set_ch(1, 1, 3); rst = 1'b0;
        v0 = '0; v1 = '0; t0 = '0; t1 = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v0 = {v0[7:0], clk_out[0]}; v1 = {v1[7:0], clk_out[1]};
            t0 = {t0[7:0], tick[0]};    t1 = {t1[7:0], tick[1]};
        end
        chk("n2_clk_pat", v0[5:0], 6'b101010);
        chk("n3_clk_pat", v1[5:0], 6'b110110);
        chk("n2_tick_pat", t0[5:0], 6'b101010);
        chk("n3_tick_pat", t1[5:0], 6'b100100);

        // Shadow update: N 4 -> 5 while at cnt=1
        set_ch(0, 0, 4); set_ch(1, 0, 3);
        @(negedge clk);
        set_ch(0, 1, 4);
        v0 = '0; t0 = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            v0 = {v0[7:0], clk_out[0]}; t0 = {t0[7:0], tick[0]};
            if (i == 1) set_ch(0, 1, 5);
        end
        chk("shadow_clk_pat", v0, 9'b110011100);
        chk("shadow_tick_pat", t0, 9'b100010000);

        // Invalid ratio, then recovery
        set_ch(0, 0, 1);
        @(negedge clk);
        set_ch(0, 1, 1);
        repeat (3) @(negedge clk);
        chk("inv_err", err[0], 1);
        chk("inv_clk", clk_out[0], 0);
        chk("inv_tick", tick[0], 0);
        set_ch(0, 1, 4);
        v0 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("rec_err", err[0], 0);
                chk("rec_tick", tick[0], 1);
            end
            v0 = {v0[7:0], clk_out[0]};
        end
        chk("rec_clk_pat", v0[3:0], 4'b1100);

        // Reset mid-period of N=6, then enable drop mid-period
        set_ch(0, 0, 6);
        @(negedge clk);
        set_ch(0, 1, 6);
        repeat (3) @(negedge clk);      // now at cnt=2
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_clk", clk_out, 0);
        chk("rst_mid_tick", tick, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_tick", tick[0], 1);
        chk("rst_rel_clk", clk_out[0], 1);
        @(negedge clk);                 // cnt=1, still high
        chk("pre_drop_clk", clk_out[0], 1);
        en[0] = 1'b0;
        @(negedge clk);
        chk("en_drop_clk", clk_out[0], 0);

        // Largest ratio 2^W-1 on channel 1
        set_ch(0, 0, 2);
        set_ch(1, 1, 255);
        ticks = 0; highs = 0;
        for (int i = 0; i < 510; i++) begin
            @(negedge clk);
            ticks += int'(tick[1]);
            if (i < 255) highs += int'(clk_out[1]);
        end
        chk("max_ticks", ticks, 2);
        chk("max_highs", highs, 128);
        set_ch(1, 0, 2);
        @(negedge clk);

`ifdef FD_GEN_DUTY_EN
        // Explicit duty: narrow, zero and over-range high time at N=5
        for (int j = 0; j < 3; j++) begin
            int d;
            logic [4:0] e;
            d = (j == 0) ? 1 : (j == 1) ? 0 : 7;
            e = (j == 0) ? 5'b10000 : (j == 1) ? 5'b00000 : 5'b11111;
            set_d(0, 0, 5, d);
            @(negedge clk);
            set_d(0, 1, 5, d);
            v0 = '0; t0 = '0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                v0 = {v0[7:0], clk_out[0]}; t0 = {t0[7:0], tick[0]};
            end
            chk($sformatf("duty%0d_clk_pat", d), v0[4:0], e);
            chk($sformatf("duty%0d_tick_pat", d), t0[4:0], 5'b10000);
        end
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fd_gen.md
FD_GEN -- requirements
Module: fd_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of each divide ratio and duty value.
REQ-002 SHALL have parameter CH, default 2, number of independent divider channels (1..16).
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  CH  per-channel run enable.
REQ-006 SHALL have port n_div  input  CH*WIDTH  per-channel divide ratio N, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port duty  input  CH*WIDTH  per-channel high-time H in clk_in cycles, same packing as n_div.
REQ-008 SHALL have port clk_out  output  CH  divided clock, registered.
REQ-009 SHALL have port tick  output  CH  one-cycle pulse coincident with the first high cycle of each output period.
REQ-010 SHALL have port err  output  CH  level flag, high while the active ratio is invalid (N<2).

Function
REQ-011 Each channel SHALL hold an active ratio Na, an active high-time Ha and a counter cnt (WIDTH bits), independent of the other channels.
REQ-012 Channel states: IDLE (en=0) and RUN; IDLE->RUN on a rising edge with en=1; RUN->IDLE on a rising edge with en=0.
REQ-013 In IDLE: cnt=0, clk_out=0, tick=0; Na and Ha SHALL be reloaded from n_div and duty every cycle.
REQ-014 On the IDLE->RUN edge: cnt<=0, tick<=1, clk_out<=(Ha>0); the first output period starts in the following cycle.
REQ-015 In RUN: cnt SHALL increment by 1 per cycle; when cnt==Na-1 it SHALL wrap to 0, assert tick for one cycle, and load Na/Ha from the inputs (shadow update at period boundary only).
REQ-016 Mid-period changes to n_div or duty SHALL NOT affect the current period, so there are no runt pulses.
REQ-017 clk_out SHALL equal 1 when next cnt < Ha, else 0; the output period is exactly Na cycles.
REQ-018 Ha >= Na SHALL give a constant-high clk_out; Ha=0 SHALL give a constant-low clk_out; tick SHALL still pulse every Na cycles in both cases.
REQ-019 Na<2 (0 or 1) SHALL force clk_out=0, tick=0 and err=1 in RUN; the channel SHALL re-sample n_div every cycle until N>=2 and then restart as in REQ-014.
REQ-020 Comparisons SHALL be unsigned at full WIDTH; N=2^WIDTH-1 SHALL be supported without overflow.

Reset
REQ-021 rst=1 at a rising edge SHALL force every channel to IDLE: cnt=0, clk_out=0, tick=0, err=0, Na=0, Ha=0.
REQ-022 rst SHALL take priority over en. Asserting rst mid-period SHALL truncate the output the next cycle.
REQ-023 After rst deasserts, a channel with en=1 SHALL enter RUN on the first edge with rst=0.

Configuration
REQ-024 Macro FD_GEN_DUTY_EN defined: Ha SHALL be loaded from the duty port.
REQ-025 Macro FD_GEN_DUTY_EN undefined: duty SHALL be ignored and Ha = N - (N>>1) (ceil(N/2)), giving 50% duty for even N and one extra high cycle for odd N.

Verification
REQ-026 Macro off, CH=2, ch0 N=2, ch1 N=3, en=2'b11 after reset -> ch0 toggles every cycle (1,0,...); ch1 pattern 1,1,0 repeating; tick every 2 and 3 cycles respectively.
REQ-027 Macro off, N=4 running, n_div changed to 5 at cnt=1 -> current period stays 4 cycles (1,1,0,0); the next period is 1,1,1,0,0.
REQ-028 Macro on, N=5, duty=1 -> pattern 1,0,0,0,0; duty=0 -> constant 0; duty=7 -> constant 1; tick every 5 cycles in all three cases.
REQ-029 n_div=1 with en=1 -> err=1 and clk_out=0 held; n_div changed to 4 -> err clears and the pattern 1,1,0,0 starts the next cycle.
REQ-030 Reset and enable: rst=1 at cnt=2 of N=6 -> all outputs 0 the next cycle and after release the channel restarts at cnt=0; en drop mid-period -> clk_out=0 the next cycle.
